// File: rtl/vga_timing_gen_aot.sv
// VGA scan timing generator: current and look-ahead coordinate pairs with
// registered display-enable, sync, line/frame strobes and a frame counter.
module vga_timing_gen_aot #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int LOOKAHEAD   = 2,
    parameter int FRAME_CNT_W = 8,
    localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL)
) (
    input  logic                   vga_pix_clk,
    input  logic                   rst_n,
    input  logic                   pix_ce,
    output logic [HW-1:0]          sx,
    output logic [VW-1:0]          sy,
    output logic                   display_enabled,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   line_stb,
    output logic                   frame_stb,
    output logic [HW-1:0]          sx_aot,
    output logic [VW-1:0]          sy_aot,
    output logic                   display_enabled_aot,
    output logic                   frame_stb_aot,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef logic [HW-1:0] hw_t;
    typedef logic [VW-1:0] vw_t;
    typedef logic [HW:0]   hx_t;
    typedef logic [VW:0]   vx_t;

    // Decode constants carry one spare bit so terminal counts never truncate.
    localparam hx_t H_LAST     = hx_t'(H_TOTAL - 1);
    localparam vx_t V_LAST     = vx_t'(V_TOTAL - 1);
    localparam hx_t H_VIS_X    = hx_t'(H_VISIBLE);
    localparam vx_t V_VIS_X    = vx_t'(V_VISIBLE);
    localparam hx_t H_SS       = hx_t'(H_VISIBLE + H_FRONT);
    localparam hx_t H_SE       = hx_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam vx_t V_SS       = vx_t'(V_VISIBLE + V_FRONT);
    localparam vx_t V_SE       = vx_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic H_POL     = logic'(H_SYNC_POL != 0);
    localparam logic V_POL     = logic'(V_SYNC_POL != 0);
    localparam hw_t  AOT_X_RST = hw_t'(LOOKAHEAD);

    function automatic logic x_is_last(hw_t x);
        return {1'b0, x} == H_LAST;
    endfunction

    function automatic hw_t next_x(hw_t x, logic ce);
        if (!ce) return x;
        return x_is_last(x) ? '0 : x + hw_t'(1);
    endfunction

    function automatic vw_t next_y(hw_t x, vw_t y, logic ce);
        if (!ce || !x_is_last(x)) return y;
        return ({1'b0, y} == V_LAST) ? '0 : y + vw_t'(1);
    endfunction

    function automatic logic in_display(hw_t x, vw_t y);
        return ({1'b0, x} < H_VIS_X) && ({1'b0, y} < V_VIS_X);
    endfunction

    function automatic logic hsync_level(hw_t x);
        return (({1'b0, x} >= H_SS) && ({1'b0, x} < H_SE)) ? H_POL : ~H_POL;
    endfunction

    function automatic logic vsync_level(vw_t y);
        return (({1'b0, y} >= V_SS) && ({1'b0, y} < V_SE)) ? V_POL : ~V_POL;
    endfunction

    hw_t  sx_nxt;
    vw_t  sy_nxt;
    hw_t  sx_aot_nxt;
    vw_t  sy_aot_nxt;
    logic cur_frame_entry;
    logic cur_line_entry;
    logic aot_frame_entry;

    // Both pairs step with identical rules; the ahead pair is never derived
    // arithmetically from the current pair.
    always_comb begin
        sx_nxt          = next_x(sx, pix_ce);
        sy_nxt          = next_y(sx, sy, pix_ce);
        sx_aot_nxt      = next_x(sx_aot, pix_ce);
        sy_aot_nxt      = next_y(sx_aot, sy_aot, pix_ce);
        cur_line_entry  = pix_ce && (sx_nxt == '0);
        cur_frame_entry = cur_line_entry && (sy_nxt == '0);
        aot_frame_entry = pix_ce && (sx_aot_nxt == '0) && (sy_aot_nxt == '0);
    end

    // Level outputs are decoded from next-state so they line up with the
    // coordinates presented in the same cycle.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            sx                  <= '0;
            sy                  <= '0;
            sx_aot              <= AOT_X_RST;
            sy_aot              <= '0;
            display_enabled     <= in_display('0, '0);
            display_enabled_aot <= in_display(AOT_X_RST, '0);
            hsync               <= hsync_level('0);
            vsync               <= vsync_level('0);
            line_stb            <= 1'b0;
            frame_stb           <= 1'b0;
            frame_stb_aot       <= 1'b0;
            frame_cnt           <= '0;
        end else begin
            sx                  <= sx_nxt;
            sy                  <= sy_nxt;
            sx_aot              <= sx_aot_nxt;
            sy_aot              <= sy_aot_nxt;
            display_enabled     <= in_display(sx_nxt, sy_nxt);
            display_enabled_aot <= in_display(sx_aot_nxt, sy_aot_nxt);
            hsync               <= hsync_level(sx_nxt);
            vsync               <= vsync_level(sy_nxt);
            line_stb            <= cur_line_entry;
            frame_stb           <= cur_frame_entry;
            frame_stb_aot       <= aot_frame_entry;
            if (cur_frame_entry) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen_aot.sv
// Bench for vga_timing_gen_aot: one full-size instance plus three small-geometry
// instances (look-ahead 0, 2, 14), checked against a linear-address model.
module tb_vga_timing_gen_aot;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, hpol, vpol, la, fcw;
    } geo_t;

    typedef struct {
        integer sx, sy, sxa, sya, de, dea, hs, vs, ls, fs, fsa, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_ce;

    always #5 clk = ~clk;

    logic [9:0] b_sx, b_sy, b_sxa, b_sya;
    logic       b_de, b_dea, b_hs, b_vs, b_ls, b_fs, b_fsa;
    logic [7:0] b_fc;

    logic [3:0] s_sx [1:3];
    logic [2:0] s_sy [1:3];
    logic [3:0] s_sxa[1:3];
    logic [2:0] s_sya[1:3];
    logic       s_de [1:3];
    logic       s_dea[1:3];
    logic       s_hs [1:3];
    logic       s_vs [1:3];
    logic       s_ls [1:3];
    logic       s_fs [1:3];
    logic       s_fsa[1:3];
    logic [1:0] s_fc [1:3];

    vga_timing_gen_aot u_big (
        .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .sx(b_sx), .sy(b_sy), .display_enabled(b_de), .hsync(b_hs), .vsync(b_vs),
        .line_stb(b_ls), .frame_stb(b_fs), .sx_aot(b_sxa), .sy_aot(b_sya),
        .display_enabled_aot(b_dea), .frame_stb_aot(b_fsa), .frame_cnt(b_fc)
    );

    for (genvar g = 1; g <= 3; g++) begin : g_small
        vga_timing_gen_aot #(
            .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
            .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
            .H_SYNC_POL(g == 3 ? 1 : 0), .V_SYNC_POL(g == 3 ? 1 : 0),
            .LOOKAHEAD(g == 1 ? 0 : (g == 2 ? 2 : 14)), .FRAME_CNT_W(2)
        ) u_small (
            .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
            .sx(s_sx[g]), .sy(s_sy[g]), .display_enabled(s_de[g]), .hsync(s_hs[g]),
            .vsync(s_vs[g]), .line_stb(s_ls[g]), .frame_stb(s_fs[g]),
            .sx_aot(s_sxa[g]), .sy_aot(s_sya[g]), .display_enabled_aot(s_dea[g]),
            .frame_stb_aot(s_fsa[g]), .frame_cnt(s_fc[g])
        );
    end

    geo_t geo[4];
    int   addr[4];
    int   fcm[4];
    exp_t sb[$];
    int   npass  = 0;
    int   ntotal = 0;
    int   cyc    = 0;

    function automatic int htot(geo_t g);
        return g.hv + g.hf + g.hs + g.hb;
    endfunction

    function automatic int vtot(geo_t g);
        return g.vv + g.vf + g.vs + g.vb;
    endfunction

    function automatic exp_t make_exp(geo_t g, int a, int ce, int fc);
        exp_t e;
        int ht, aa;
        ht = htot(g);
        aa = (a + g.la) % (ht * vtot(g));
        e.sx  = a % ht;
        e.sy  = a / ht;
        e.sxa = aa % ht;
        e.sya = aa / ht;
        e.de  = (e.sx < g.hv && e.sy < g.vv) ? 1 : 0;
        e.dea = (e.sxa < g.hv && e.sya < g.vv) ? 1 : 0;
        e.hs  = (e.sx >= g.hv + g.hf && e.sx < g.hv + g.hf + g.hs) ? g.hpol : 1 - g.hpol;
        e.vs  = (e.sy >= g.vv + g.vf && e.sy < g.vv + g.vf + g.vs) ? g.vpol : 1 - g.vpol;
        e.ls  = (ce != 0 && e.sx == 0) ? 1 : 0;
        e.fs  = (ce != 0 && a == 0) ? 1 : 0;
        e.fsa = (ce != 0 && aa == 0) ? 1 : 0;
        e.fc  = fc;
        return e;
    endfunction

    function automatic exp_t obs(int k);
        exp_t o;
        if (k == 0) begin
            o.sx = b_sx;  o.sy = b_sy;  o.sxa = b_sxa; o.sya = b_sya;
            o.de = b_de;  o.dea = b_dea; o.hs = b_hs;  o.vs = b_vs;
            o.ls = b_ls;  o.fs = b_fs;  o.fsa = b_fsa; o.fc = b_fc;
        end else begin
            o.sx = s_sx[k];  o.sy = s_sy[k];  o.sxa = s_sxa[k]; o.sya = s_sya[k];
            o.de = s_de[k];  o.dea = s_dea[k]; o.hs = s_hs[k];  o.vs = s_vs[k];
            o.ls = s_ls[k];  o.fs = s_fs[k];  o.fsa = s_fsa[k]; o.fc = s_fc[k];
        end
        return o;
    endfunction

    task automatic chk(input string tag, input integer o, input integer e);
        ntotal++;
        assert (o === e) begin
            npass++;
        end else begin
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
        end
    endtask

    task automatic cmp(input int k, input exp_t o, input exp_t e);
        int ht;
        ht = htot(geo[k]);
        chk($sformatf("u%0d.sx", k), o.sx, e.sx);
        chk($sformatf("u%0d.sy", k), o.sy, e.sy);
        chk($sformatf("u%0d.sx_aot", k), o.sxa, e.sxa);
        chk($sformatf("u%0d.sy_aot", k), o.sya, e.sya);
        chk($sformatf("u%0d.display_enabled", k), o.de, e.de);
        chk($sformatf("u%0d.display_enabled_aot", k), o.dea, e.dea);
        chk($sformatf("u%0d.hsync", k), o.hs, e.hs);
        chk($sformatf("u%0d.vsync", k), o.vs, e.vs);
        chk($sformatf("u%0d.line_stb", k), o.ls, e.ls);
        chk($sformatf("u%0d.frame_stb", k), o.fs, e.fs);
        chk($sformatf("u%0d.frame_stb_aot", k), o.fsa, e.fsa);
        chk($sformatf("u%0d.frame_cnt", k), o.fc, e.fc);
        chk($sformatf("u%0d.invariant", k), o.sya * ht + o.sxa,
            (o.sy * ht + o.sx + geo[k].la) % (ht * vtot(geo[k])));
    endtask

    task automatic step(input logic ce);
        pix_ce = ce;
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                addr[k] = 0;
                fcm[k]  = 0;
            end else if (ce) begin
                addr[k] = (addr[k] + 1) % (htot(geo[k]) * vtot(geo[k]));
                if (addr[k] == 0) fcm[k] = (fcm[k] + 1) % (1 << geo[k].fcw);
            end
            sb.push_back(make_exp(geo[k], addr[k], (rst_n && ce) ? 1 : 0, fcm[k]));
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) cmp(k, obs(k), sb.pop_front());
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            addr[k] = 0;
            fcm[k]  = 0;
            sb.push_back(make_exp(geo[k], 0, 0, 0));
        end
        for (int k = 0; k < 4; k++) cmp(k, obs(k), sb.pop_front());
    endtask

    initial begin
        int hcnt, lcnt, dcnt, vcnt, vpcnt, fcnt, ta, lead_done, found;
        geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 8};
        geo[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 0, 2};
        geo[2] = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 2, 2};
        geo[3] = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 1, 14, 2};
        rst_n  = 1'b0;
        pix_ce = 1'b1;

        // Reset held with pix_ce high: everything stays at reset values.
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        chk("release_sx", b_sx, 1);
        chk("release_sx_aot", b_sxa, 3);

        // One full line on the big instance: hsync width and single line strobe.
        hcnt = 0;
        lcnt = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (b_hs == 1'b0) hcnt++;
            if (b_ls == 1'b1) lcnt++;
        end
        chk("hsync_ticks_per_line", hcnt, 96);
        chk("line_stb_per_line", lcnt, 1);

        // One full small frame: display-enable and vsync coverage.
        dcnt = 0; vcnt = 0; vpcnt = 0; fcnt = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1);
            if (s_de[2] == 1'b1) dcnt++;
            if (s_vs[2] == 1'b0) vcnt++;
            if (s_vs[3] == 1'b1) vpcnt++;
            if (s_fs[2] == 1'b1) fcnt++;
        end
        chk("de_ticks_per_frame", dcnt, 32);
        chk("vsync_ticks_per_frame", vcnt, 30);
        chk("vsync_pos_pol_ticks", vpcnt, 30);
        chk("frame_stb_per_frame", fcnt, 1);

        // pix_ce at 1-in-4: frame_stb_aot must lead frame_stb by 8 clocks.
        ta = -1;
        lead_done = 0;
        for (int i = 0; i < 520; i++) begin
            step((i % 4) == 0);
            if (s_fsa[2] == 1'b1) ta = cyc;
            if (s_fs[2] == 1'b1 && ta >= 0 && lead_done == 0) begin
                chk("frame_stb_lead_clocks", cyc - ta, 8);
                lead_done = 1;
            end
        end
        chk("frame_stb_lead_seen", lead_done, 1);

        // Random clock-enable over several small frames.
        for (int i = 0; i < 1500; i++) step(1'(($urandom_range(0, 1))));

        // Mid-frame async reset on the big instance at sx=300.
        found = 0;
        for (int i = 0; i < 800 && found == 0; i++) begin
            step(1'b1);
            if (b_sx == 10'd300) found = 1;
        end
        chk("reached_sx_300", found, 1);
        async_reset();
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen_aot.md
# vga_timing_gen_aot

Parametrised VGA timing generator for the pixel pipeline. It produces the current scan coordinates and aligned sync and display-enable signals. It also produces a second coordinate set that runs LOOKAHEAD pixel ticks ahead, so drawing logic with LOOKAHEAD pipeline stages lands exactly on the displayed pixel. It replaces the fixed-timing signal generator plus combinational ahead-of-time arithmetic. It adds a pixel clock-enable, sync polarity, line/frame strobes and a frame counter.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- H_SYNC_POL, 0, active level of hsync
- V_SYNC_POL, 0, active level of vsync
- LOOKAHEAD, 2, pixel ticks the _aot outputs lead; legal range 0..H_TOTAL-1
- FRAME_CNT_W, 8, frame counter width
- Derived: H_TOTAL = sum of H terms (800), V_TOTAL = sum of V terms (525), HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL)
- vga_pix_clk  in  1  pixel-domain clock, single clock for the whole block
- rst_n  in  1  reset, asynchronous assert, active-low
- pix_ce  in  1  pixel tick enable; tie high to run at the clock rate
- sx, sy  out  HW, VW  current coordinates
- display_enabled  out  1  high when sx<H_VISIBLE and sy<V_VISIBLE
- hsync, vsync  out  1  sync outputs at the programmed polarity
- line_stb, frame_stb  out  1  one-cycle pulses on entry to sx==0 and to (0,0)
- sx_aot, sy_aot  out  HW, VW  coordinates LOOKAHEAD ticks ahead
- display_enabled_aot, frame_stb_aot  out  1  same decode and pulse as the current set, applied to the _aot coordinates
- frame_cnt  out  FRAME_CNT_W  completed frames, modulo 2^FRAME_CNT_W

## Operation
- Two independent register counter pairs are used: current (sx,sy) and ahead (sx_aot,sy_aot). No adder/modulo path runs from sx to sx_aot.
- On a cycle with pix_ce=1, each pair advances: x+1. When x==H_TOTAL-1, x goes to 0 and y goes to y+1. When y==V_TOTAL-1 also, y goes to 0.
- When pix_ce=0, all counters, levels and frame_cnt hold and all strobes are 0.
- The ahead pair's reset value is (LOOKAHEAD, 0). With LOOKAHEAD=0 both pairs are identical.
- Invariant: (sy_aot*H_TOTAL+sx_aot) == (sy*H_TOTAL+sx+LOOKAHEAD) mod (H_TOTAL*V_TOTAL) at every clock.
- hsync is active when H_VISIBLE+H_FRONT <= sx < H_VISIBLE+H_FRONT+H_SYNC. vsync is active when V_VISIBLE+V_FRONT <= sy < V_VISIBLE+V_FRONT+V_SYNC. Otherwise each is at the inverse of its polarity.
- display_enabled, hsync, vsync and all strobes are registered. They are decoded from the next-state counters, so they are cycle-aligned with the sx/sy presented in the same cycle.
- frame_cnt increments (wrapping) on the same tick that the current pair wraps to (0,0).
- Internal comparisons use HW/VW+1 bits. There is no truncation on the terminal count.

## Timing
- Reset (async, rst_n=0) drives the following values immediately:
  - sx=0, sy=0, sx_aot=LOOKAHEAD, sy_aot=0
  - display_enabled=1, display_enabled_aot=1
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - all strobes 0, frame_cnt=0
- Deassertion is assumed synchronised externally. The first advance occurs on the first pix_ce=1 edge after release.
- Reset mid-frame aborts the frame. There is no strobe on reset, and frame_cnt is not incremented.
- Output latency from pix_ce to a new coordinate is 1 clock. Strobes last exactly one clock, including when pix_ce is held high.
- frame_stb_aot precedes frame_stb by exactly LOOKAHEAD pix_ce ticks. The same lead applies to line entry.
- No output glitches: every output is a flop.

## Test plan
- Reset: hold rst_n=0 with pix_ce=1 -> sx=0, sy=0, sx_aot=2, sy_aot=0, hsync=1, vsync=1, frame_cnt=0, strobes 0. Release -> next clock gives sx=1, sx_aot=3.
- Line wrap: run to sx=799, sy=0 -> next tick gives sx=0, sy=1, line_stb=1 for one cycle. sx_aot=0 and sy_aot=1 must already hold at sx=798, sy=0.
- Frame wrap: sx=798, sy=524 -> sx_aot=0, sy_aot=0, frame_stb_aot=1. Two ticks later sx=0, sy=0, frame_stb=1, frame_cnt 0->1.
- Sync widths: over one full frame, hsync=0 exactly for sx 656..751 (96 ticks per line) and vsync=0 exactly for sy 490..491. display_enabled is high for 640x480 = 307200 ticks per frame.
- Clock enable: pix_ce toggled 1-in-4 -> coordinates advance once per 4 clocks, strobes stay one clock wide, and frame_stb_aot leads frame_stb by 2 ticks (8 clocks).
- Invariant and mid-frame reset: random pix_ce over 3 frames with LOOKAHEAD=0, 2 and 799, checking the linear-address invariant every clock. Asserting rst_n=0 at sx=300, sy=200 -> outputs return to reset values within the same cycle, with no frame_stb.
